// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM freeze controller.
// The 32-bit word is split into two 16-bit half-word accesses on the pins.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
    localparam int          SRAM_ADDR_W       = 18;
    localparam int          SRAM_DATA_W       = 16;
    localparam int          WORD_W            = SRAM_ADDR_W - 1;
    localparam int          CNT_W             = 4;

    // Out-of-range addresses simply wrap; the upper offset bits are dropped.
    function automatic logic [WORD_W-1:0] word_index(input logic [31:0] byte_addr,
                                                     input logic [31:0] base_addr);
        logic [31:0] offset;
        offset = byte_addr - base_addr;
        return offset[WORD_W+1:2];
    endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Wait-state counter for one half-word phase: counts 0..HALF_CYCLES-1 and
// wraps to zero on the terminal count so the next phase starts fresh.
module sram_phase_counter
    import mem_ctrl_pkg::*;
#(
    parameter int HALF_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_CYCLES - 1);

    assign terminal = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_freeze_ctrl.sv
// Stalls the pipeline while a 32-bit load/store is carried out as two
// 16-bit SRAM accesses, then releases it for one cycle with rdata valid.
module mem_freeze_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          HALF_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   freeze,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_we_n
);

    localparam bit SINGLE_CYCLE = (HALF_CYCLES == 1);

    mem_state_t        state;
    mem_state_t        state_next;
    logic              req;
    logic              op_write;
    logic [WORD_W-1:0] word_q;
    logic [31:0]       wdata_q;
    logic              cnt_clear;
    logic              cnt_en;
    logic [CNT_W-1:0]  phase_count;
    logic              phase_term;
    logic              strobe;

    assign req = mem_r_en | mem_w_en;

    sram_phase_counter #(
        .HALF_CYCLES(HALF_CYCLES)
    ) u_phase_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .count   (phase_count),
        .terminal(phase_term)
    );

    // The last cycle of a phase keeps address and data on the pins with the
    // strobe released, unless the phase is only one cycle long.
    assign strobe = op_write & (~phase_term | SINGLE_CYCLE);

    always_comb begin
        state_next  = state;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;
        freeze      = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (req) begin
                    freeze     = 1'b1;
                    state_next = ST_LOW;
                end
            end
            ST_LOW: begin
                freeze    = 1'b1;
                cnt_en    = 1'b1;
                sram_addr = {word_q, 1'b0};
                if (op_write) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[15:0];
                    sram_we_n   = ~strobe;
                end
                if (phase_term) begin
                    state_next = ST_HIGH;
                end
            end
            ST_HIGH: begin
                freeze    = 1'b1;
                cnt_en    = 1'b1;
                sram_addr = {word_q, 1'b1};
                if (op_write) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[31:16];
                    sram_we_n   = ~strobe;
                end
                if (phase_term) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                cnt_clear  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_write <= 1'b0;
            word_q   <= '0;
            wdata_q  <= '0;
            rdata    <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && req) begin
                op_write <= mem_w_en;
                word_q   <= word_index(addr, BASE_ADDR);
                wdata_q  <= wdata;
            end
            if (state == ST_LOW && phase_term && !op_write) begin
                rdata[15:0] <= sram_dq_in;
            end
            if (state == ST_HIGH && phase_term && !op_write) begin
                rdata[31:16] <= sram_dq_in;
            end
        end
    end

endmodule

// File: doc/mem_freeze_ctrl.md
Name: mem_freeze_ctrl

Overview:
- Drives the pipeline-wide freeze signal. Every pipeline register loads on ~freeze.
- Services MEM-stage loads and stores against an external 16-bit SRAM, which needs two half-word accesses per 32-bit word with fixed wait states.
- Holds freeze high until the access completes, then releases the pipeline for exactly one cycle with read data valid.
- Sits between the MEM stage and the board SRAM pins, on the producing side of the register load-enable interface.

Parameters:
- HALF_CYCLES, 3, cycles spent in each half-word phase (valid range 1 to 15).
- BASE_ADDR, 32'd1024, byte address that maps to SRAM word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- mem_r_en  in  1  MEM-stage load request.
- mem_w_en  in  1  MEM-stage store request.
- addr  in  32  byte address from the ALU result.
- wdata  in  32  store data.
- rdata  out  32  load data, valid in the DONE cycle and held afterwards.
- freeze  out  1  high stalls all pipeline registers.
- sram_addr  out  18  {word[16:0], half}; half=0 selects the low half-word.
- sram_dq_out  out  16  write data to the pins.
- sram_dq_oe  out  1  pad output enable (high drives the bus).
- sram_dq_in  in  16  read data from the pins.
- sram_we_n  out  1  active-low write strobe.

Behaviour:
- Reset:
  - state=IDLE, counter=0, rdata=0.
  - freeze=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
- Request detection: req = mem_r_en | mem_w_en.
  - If both are high, the access is treated as a write.
  - The op type, address and wdata are latched on IDLE→LOW.
- Word index: word = ((addr - BASE_ADDR) >> 2)[16:0]. Out-of-range addresses wrap modulo 2^17 with no error.
- FSM states IDLE, LOW, HIGH, DONE:
  - IDLE: if req, go to LOW with counter=0. Otherwise stay.
  - LOW: counter increments. On counter==HALF_CYCLES-1, capture the low half, reset the counter, go to HIGH.
  - HIGH: same counting. On the terminal count, capture the high half, go to DONE.
  - DONE: one cycle, then IDLE unconditionally.
- freeze (combinational):
  - High in IDLE when req is high.
  - High throughout LOW and HIGH.
  - Low in DONE and in idle-without-request.
  - Total freeze = 2*HALF_CYCLES+1 cycles per access (7 at default). The pipeline advances on the DONE edge.
- Back-to-back requests: the DONE→IDLE cycle sees the next instruction's request, so a new access starts from IDLE one cycle after DONE. DONE never chains directly into LOW.
- SRAM drive:
  - sram_addr = {word, 0} in LOW and {word, 1} in HIGH, from registered values.
  - Write: sram_dq_out = wdata[15:0] in LOW and wdata[31:16] in HIGH. sram_dq_oe=1 in both phases.
  - Write strobe: sram_we_n=0 in every phase cycle except the last one, which gives address/data hold. If HALF_CYCLES==1, sram_we_n=0 for that single cycle.
  - Read: sram_dq_oe=0, sram_we_n=1. sram_dq_in is sampled on the terminal-count edge of each phase.
- rdata:
  - Updates only on a completed read: low half at end of LOW, high half at end of HIGH.
  - A write leaves rdata unchanged.
- Request dropping mid-access (illegal while frozen): the access still runs to DONE.
- rst asserted mid-access:
  - Abort to IDLE next edge, with all reset values.
  - A partial write is not completed.
- Counter width is 4 bits. It never exceeds HALF_CYCLES-1.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - the state enum (IDLE, LOW, HIGH, DONE);
  - the BASE_ADDR default;
  - the SRAM address/data widths (18/16).
- Sub-module sram_phase_counter:
  - Inputs: clk, rst, clear, enable.
  - Outputs: count and terminal flag, parameterised by HALF_CYCLES.
  - The main FSM instantiates one.

Test Plan:
- Single load, addr=1024+8, SRAM word 2 = {16'hBEEF high, 16'hCAFE low} → sram_addr 4 then 5; freeze high exactly 7 cycles; rdata=32'hBEEFCAFE in DONE; freeze low that cycle.
- Single store, addr=1024+12, wdata=32'h12345678 → sram_addr 6 with dq_out 16'h5678, then 7 with 16'h1234; sram_we_n low for 2 of the 3 cycles per phase; oe high; rdata unchanged.
- Store immediately followed by load of the same address → one IDLE gap cycle between accesses; load returns 32'h12345678; freeze pattern is 7 high, 1 low, 7 high, 1 low.
- Reset asserted in cycle 2 of HIGH during a store → next edge: IDLE, freeze=0, we_n=1, oe=0, rdata=0; no further SRAM writes.
- mem_r_en and mem_w_en both high, addr=1020 → treated as a write to wrapped word 17'h1FFFF (sram_addr 18'h3FFFE/18'h3FFFF).
- HALF_CYCLES=1 build, single load → freeze high 3 cycles; we_n stays 1; rdata correct in DONE.
